sprite_engine: RTL and testbench

SPRITE_ENGINE -- requirements
Module: sprite_engine

---
 rtl/sprite_engine.sv | 159 +++++++++++++++
 tb/tb_sprite_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - rectangular sprite draw/erase engine driving a VGA pixel-write port
// One request produces an optional origin shift, a row-major pixel scan and a one-cycle complete pulse.
module sprite_engine #(
  parameter int         WIDTH     = 16,
  parameter int         HEIGHT    = 16,
  parameter int         X_MAX     = 180,
  parameter int         Y_MAX     = 104,
  parameter logic [2:0] COLOUR    = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [7:0] RESET_X   = 8'd0,
  parameter logic [6:0] RESET_Y   = 7'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] load_x,
  input  logic [6:0] load_y,
  input  logic       writeEn,
  input  logic       clear,
  input  logic       shift_h,
  input  logic       shift_v,
  input  logic [6:0] shift_amount,
  input  logic [6:0] shift_amount_two,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       complete
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic signed [9:0] X_MAX_S = 10'(X_MAX);
  localparam logic signed [9:0] Y_MAX_S = 10'(Y_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, SCAN, DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_pos_x;
  logic [6:0]    r_pos_y;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_erase;
  logic          r_sel_h;
  logic [6:0]    r_amt_a;
  logic [6:0]    r_amt_b;
  logic          w_plot;
  logic          w_complete;
  logic          w_last;
  logic          w_req;

  // Wide enough that any 8-bit origin plus a 7-bit signed delta cannot wrap before clamping.
  function automatic logic [7:0] sat_x(input logic [7:0] base, input logic [6:0] d);
    logic signed [9:0] s;
    s = $signed({2'b00, base}) + $signed({{3{d[6]}}, d});
    if (s < 10'sd0)        return 8'd0;
    else if (s > X_MAX_S)  return 8'(X_MAX);
    else                   return s[7:0];
  endfunction

  function automatic logic [6:0] sat_y(input logic [6:0] base, input logic [6:0] d);
    logic signed [9:0] s;
    s = $signed({3'b000, base}) + $signed({{3{d[6]}}, d});
    if (s < 10'sd0)        return 7'd0;
    else if (s > Y_MAX_S)  return 7'(Y_MAX);
    else                   return s[6:0];
  endfunction

  assign w_last = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_req  = enable && writeEn && (clear || shift_h || shift_v);

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_plot      = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE:  if (w_req) w_state_nxt = clear ? SCAN : SHIFT;
      SHIFT: w_state_nxt = enable ? SCAN : IDLE;
      SCAN: begin
        w_plot = 1'b1;
        if (!enable)     w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_complete  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pos_x <= RESET_X;
      r_pos_y <= RESET_Y;
      r_col   <= '0;
      r_row   <= '0;
      r_erase <= 1'b0;
      r_sel_h <= 1'b0;
      r_amt_a <= '0;
      r_amt_b <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && load && !writeEn) begin
            r_pos_x <= load_x;
            r_pos_y <= load_y;
          end
          if (enable && writeEn) begin
            r_erase <= clear;
            r_sel_h <= shift_h;
            r_amt_a <= shift_amount;
            r_amt_b <= shift_amount_two;
          end
        end
        // The shifted origin is committed even if enable drops during this cycle.
        SHIFT: begin
          if (r_sel_h) begin
            r_pos_x <= sat_x(r_pos_x, r_amt_a);
            r_pos_y <= sat_y(r_pos_y, r_amt_b);
          end else begin
            r_pos_y <= sat_y(r_pos_y, r_amt_a);
          end
        end
        SCAN: begin
          if (!enable || w_last) begin
            r_col <= '0;
            r_row <= '0;
          end else if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign plot     = w_plot;
  assign complete = w_complete;
  assign x_out    = w_plot ? r_pos_x + 8'(r_col) : 8'd0;
  assign y_out    = w_plot ? r_pos_y + 7'(r_row) : 7'd0;
  assign colour   = w_plot ? (r_erase ? BG_COLOUR : COLOUR) : 3'b000;

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - randomized self-checking bench for sprite_engine against an origin/pixel model
module tb_sprite_engine;
  localparam int W = 16;
  localparam int H = 16;
  localparam int NPIX = W * H;
  localparam int XM = 180;
  localparam int YM = 104;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [7:0] load_x;
  logic [6:0] load_y;
  logic       writeEn;
  logic       clear;
  logic       shift_h;
  logic       shift_v;
  logic [6:0] shift_amount;
  logic [6:0] shift_amount_two;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       complete;

  int n_tests = 0;
  int n_fail  = 0;
  int mx = 0;
  int my = 0;

  sprite_engine dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_x(load_x), .load_y(load_y), .writeEn(writeEn), .clear(clear),
    .shift_h(shift_h), .shift_v(shift_v), .shift_amount(shift_amount),
    .shift_amount_two(shift_amount_two), .pos_x(pos_x), .pos_y(pos_y),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .complete(complete)
  );

  always #5 clock = ~clock;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int sext7(input logic [6:0] v);
    return v[6] ? int'(v) - 128 : int'(v);
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic check_pos(input string tag);
    expect_eq(tag, {17'd0, pos_x, pos_y}, {17'd0, 8'(mx), 7'(my)});
  endtask

  task automatic check_quiet(input string tag, input logic exp_complete);
    expect_eq(tag, {13'd0, plot, complete, x_out, y_out, colour},
              {13'd0, 1'b0, exp_complete, 8'd0, 7'd0, 3'd0});
  endtask

  task automatic do_load(input int x, input int y);
    enable = 1'b1; load = 1'b1; writeEn = 1'b0;
    load_x = 8'(x); load_y = 7'(y);
    tick();
    load = 1'b0;
    mx = x; my = y;
    check_pos("load_pos");
    check_quiet("load_quiet", 1'b0);
  endtask

  // kind: 0 erase, 1 shift_h, 2 shift_v; stop_at: last pixel shown before abort (-1 none); how: 0 enable drop, 1 reset
  task automatic run_pass(input int kind, input logic [6:0] a, input logic [6:0] b,
                          input int stop_at, input int how);
    logic [2:0] exp_col;
    int r;
    int c;
    exp_col = (kind == 0) ? 3'b000 : 3'b111;
    enable = 1'b1; writeEn = 1'b1;
    clear   = (kind == 0);
    shift_h = (kind == 1) || (kind == 0 && $urandom_range(1) == 1);
    shift_v = (kind == 2) || (kind != 2 && $urandom_range(1) == 1);
    shift_amount = a; shift_amount_two = b;
    tick();
    writeEn = 1'b0; clear = 1'b0; shift_h = 1'b0; shift_v = 1'b0;
    load = 1'b1; load_x = 8'($urandom); load_y = 7'($urandom);
    if (kind != 0) begin
      check_quiet("shift_cycle", 1'b0);
      if (kind == 1) begin
        mx = clamp(mx + sext7(a), XM);
        my = clamp(my + sext7(b), YM);
      end else begin
        my = clamp(my + sext7(a), YM);
      end
      tick();
      check_pos("shift_pos");
    end
    for (int p = 0; p < NPIX; p++) begin
      r = p / W;
      c = p % W;
      expect_eq("pixel", {13'd0, plot, complete, x_out, y_out, colour},
                {13'd0, 1'b1, 1'b0, 8'(mx + c), 7'(my + r), exp_col});
      if (p == stop_at) begin
        load = 1'b0;
        if (how == 0) begin
          enable = 1'b0;
          tick();
          check_quiet("abort_idle", 1'b0);
          tick();
          check_quiet("abort_no_done", 1'b0);
          check_pos("abort_pos");
          enable = 1'b1;
        end else begin
          reset = 1'b0;
          tick();
          mx = 0; my = 0;
          check_quiet("reset_idle", 1'b0);
          check_pos("reset_pos");
          reset = 1'b1;
          tick();
          check_quiet("reset_no_done", 1'b0);
        end
        return;
      end
      if (p == NPIX - 1) load = 1'b0;
      tick();
    end
    check_quiet("done_pulse", 1'b1);
    check_pos("done_pos");
    tick();
    check_quiet("back_idle", 1'b0);
  endtask

  initial begin
    int op;
    reset = 1'b0; enable = 1'b0; load = 1'b0; load_x = '0; load_y = '0;
    writeEn = 1'b0; clear = 1'b0; shift_h = 1'b0; shift_v = 1'b0;
    shift_amount = '0; shift_amount_two = '0;
    tick();
    tick();
    check_quiet("reset_out", 1'b0);
    check_pos("reset_origin");
    reset = 1'b1;
    tick();

    do_load(72, 52);
    run_pass(0, 7'h00, 7'h00, -1, 0);
    run_pass(2, 7'h7F, 7'h00, -1, 0);
    do_load(179, 0);
    run_pass(1, 7'h02, 7'h7F, -1, 0);
    do_load(1, 10);
    run_pass(1, 7'h7E, 7'h00, -1, 0);
    do_load(20, 120);
    run_pass(0, 7'h00, 7'h00, 99, 0);
    run_pass(0, 7'h00, 7'h00, -1, 0);
    do_load(40, 40);
    run_pass(1, 7'h03, 7'h03, 50, 1);

    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(3);
      case (op)
        0: do_load($urandom_range(XM), $urandom_range(127));
        1: run_pass(0, 7'($urandom), 7'($urandom), -1, 0);
        2: run_pass(1, 7'($urandom), 7'($urandom), -1, 0);
        default: run_pass(2, 7'($urandom), 7'($urandom), -1, 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
